// File: rtl/mul_shift_add_seq.sv
// mul_shift_add_seq
//   Fixed-latency radix-2 shift-and-add multiplier. Operands arrive serially
//   on data_in: multiplicand A on the accepted start cycle, multiplier B on
//   the next cycle. The datapath multiplies magnitudes and fixes up the sign
//   of the result at the end, so signed and unsigned modes share one adder.
//   A result takes WIDTH+2 cycles from start acceptance, independent of the
//   operand values.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request a multiply (honoured only while busy=0)
//   sgn      : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   data_in  : operand bus (A on the start cycle, B on the following cycle)
//   busy     : operation in flight (LOADB / CALC)
//   done     : one-cycle result strobe
//   product  : 2*WIDTH-bit registered result, held until the next result
//   ovf      : result does not fit in WIDTH bits (signed or unsigned sense)
module mul_shift_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADB,
        S_CALC,
        S_DONE
    } state_t;

    state_t               state_q,   state_d;
    logic                 sgn_q,     sgn_d;
    logic                 sa_q,      sa_d;
    logic                 sb_q,      sb_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplr_q,    mplr_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q,     ovf_d;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    // Iteration index counts up while the counter counts down.
    logic [CW-1:0]        idx;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   res;
    logic [WIDTH:0]       hi_s;
    logic                 ovf_res;

    assign idx     = CW'(WIDTH-1) - cnt_q;
    assign addend  = {{WIDTH{1'b0}}, mcand_q} << idx;
    assign acc_sum = acc_q + (mplr_q[0] ? addend : '0);
    assign res     = (sgn_q && (sa_q ^ sb_q)) ? (~acc_sum + ONE_2W) : acc_sum;
    // Signed fit: the top WIDTH+1 bits must all equal the result sign.
    assign hi_s    = res[2*WIDTH-1:WIDTH-1];
    assign ovf_res = sgn_q ? !((&hi_s) || !(|hi_s))
                           : (|res[2*WIDTH-1:WIDTH]);

    always_comb begin
        state_d   = state_q;
        sgn_d     = sgn_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    sgn_d   = sgn;
                    sa_d    = sgn && data_in[WIDTH-1];
                    mcand_d = mag(data_in, sgn);
                    state_d = S_LOADB;
                end
            end
            S_LOADB: begin
                mplr_d  = mag(data_in, sgn_q);
                sb_d    = sgn_q && data_in[WIDTH-1];
                acc_d   = '0;
                cnt_d   = CW'(WIDTH-1);
                state_d = S_CALC;
            end
            S_CALC: begin
                acc_d  = acc_sum;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    product_d = res;
                    ovf_d     = ovf_res;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sgn_q     <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sgn_q     <= sgn_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q == S_LOADB) || (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_shift_add_seq.sv
module tb_mul_shift_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st16, sg16, bz16, dn16, o16;
    logic [15:0] d16;
    logic [31:0] p16;
    logic        st8, sg8, bz8, dn8, o8;
    logic [7:0]  d8;
    logic [15:0] p8;

    mul_shift_add_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .sgn(sg16), .data_in(d16),
        .busy(bz16), .done(dn16), .product(p16), .ovf(o16)
    );

    mul_shift_add_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .sgn(sg8), .data_in(d8),
        .busy(bz8), .done(dn8), .product(p8), .ovf(o8)
    );

    typedef struct {
        logic [31:0] p;
        logic        o;
    } exp_t;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic        o;
    } vec_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    vec_t vecs[10];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (dn16) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done16_unexpected: got done with empty scoreboard");
            end else begin
                e16 = q16.pop_front();
                chk("product16", p16, e16.p);
                chk("ovf16", {31'b0, o16}, {31'b0, e16.o});
            end
        end
        if (dn8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done8_unexpected: got done with empty scoreboard");
            end else begin
                e8 = q8.pop_front();
                chk("product8", {16'b0, p8}, e8.p);
                chk("ovf8", {31'b0, o8}, {31'b0, e8.o});
            end
        end
    end

    // One operation; returns on the negedge where done is seen.
    // now=1 drives start in the current cycle (used for back-to-back).
    task automatic run_op(input bit w8, input bit s, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] ep, input bit eo, input bit now, input int glitch);
        int lat;
        bit busy_ok;
        bit bz, dn;
        if (!now) @(negedge clk);
        if (w8) begin st8 = 1'b1; sg8 = s; d8 = a[7:0]; end
        else    begin st16 = 1'b1; sg16 = s; d16 = a; end
        @(posedge clk);
        if (w8) q8.push_back(exp_t'{ep, eo});
        else    q16.push_back(exp_t'{ep, eo});
        @(negedge clk);
        if (w8) begin st8 = 1'b0; d8 = b[7:0]; end
        else    begin st16 = 1'b0; d16 = b; end
        lat = 1;
        busy_ok = 1'b1;
        bz = 1'b0;
        while (lat < 100) begin
            bz = w8 ? bz8 : bz16;
            dn = w8 ? dn8 : dn16;
            if (dn) break;
            if (!bz) busy_ok = 1'b0;
            if (glitch != 0 && lat == glitch) begin st16 = 1'b1; d16 = 16'hbeef; end
            if (glitch != 0 && lat == glitch + 1) st16 = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("busy_pattern", {31'b0, busy_ok}, 32'd1);
        chk("busy_at_done", {31'b0, bz}, 32'd0);
        chk("latency", lat, w8 ? 32'd10 : 32'd18);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        vecs[0] = '{1'b0, 16'd17,   16'd5,    32'd85,         1'b0};
        vecs[1] = '{1'b0, 16'h0000, 16'd1234, 32'h0000_0000,  1'b0};
        vecs[2] = '{1'b1, 16'hFFFD, 16'd7,    32'hFFFF_FFEB,  1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000,  1'b1};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001,  1'b0};
        vecs[5] = '{1'b0, 16'h8000, 16'h0002, 32'h0001_0000,  1'b1};
        vecs[6] = '{1'b0, 16'h00FF, 16'h0101, 32'h0000_FFFF,  1'b0};
        vecs[7] = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001,  1'b1};
        vecs[8] = '{1'b1, 16'h00FF, 16'hFF00, 32'hFFFF_0100,  1'b1};
        vecs[9] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001,  1'b1};

        rst = 1'b1;
        st16 = 1'b0; sg16 = 1'b0; d16 = '0;
        st8  = 1'b0; sg8  = 1'b0; d8  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, bz16}, 32'd0);
        chk("rst_done", {31'b0, dn16}, 32'd0);
        chk("rst_product", p16, 32'd0);
        chk("rst_ovf", {31'b0, o16}, 32'd0);
        chk("rst_product8", {16'b0, p8}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(1'b0, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, 1'b0, 0);

        // Abort at CALC iteration 5: rst sampled on edge 7 after acceptance.
        @(negedge clk);
        st16 = 1'b1; sg16 = 1'b0; d16 = 16'd17;
        @(posedge clk);
        @(negedge clk);
        st16 = 1'b0; d16 = 16'd5;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, bz16}, 32'd0);
        chk("abort_done", {31'b0, dn16}, 32'd0);
        chk("abort_product", p16, 32'd0);
        chk("abort_ovf", {31'b0, o16}, 32'd0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (dn16) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        run_op(1'b0, 1'b0, 16'd17, 16'd5, 32'd85, 1'b0, 1'b0, 0);

        // start pulsed mid-CALC must be ignored.
        run_op(1'b0, 1'b1, 16'd100, 16'hFED4, 32'hFFFF_8AD0, 1'b0, 1'b0, 8);

        // Back-to-back: second start issued in the DONE cycle of the first.
        run_op(1'b0, 1'b0, 16'd17, 16'd5, 32'd85, 1'b0, 1'b0, 0);
        run_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 1'b1, 0);
        run_op(1'b0, 1'b1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB, 1'b0, 1'b1, 0);

        // WIDTH=8 signed corner.
        run_op(1'b1, 1'b1, 16'h0080, 16'h007F, 32'h0000_C080, 1'b1, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("sb16_empty", q16.size(), 32'd0);
        chk("sb8_empty", q8.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_shift_add_seq.md
# mul_shift_add_seq

Parametrised sequential multiplier and the successor of the 16-bit repeated-addition multiplier. It replaces the data-dependent add/decrement loop with a fixed-latency radix-2 shift-and-add datapath and an internal controller, and adds signed mode and an overflow flag. Operands arrive serially on one shared `data_in` bus (multiplicand first, multiplier second), as in the existing multiplier testbench flow. A start/busy/done handshake connects the block to the surrounding control logic.

## Interface
- `WIDTH`, default 16: operand width in bits; legal range 2–32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply; sampled only when `busy`=0.
- `sgn` input 1: operand mode, 1 = two's-complement signed, 0 = unsigned; sampled with `start`.
- `data_in` input WIDTH: operand bus; multiplicand A on the start cycle, multiplier B on the following cycle.
- `busy` output 1: high in states LOADB and CALC.
- `done` output 1: one-cycle pulse, high in state DONE.
- `product` output 2*WIDTH: registered result, held until the next result is written.
- `ovf` output 1: result does not fit in WIDTH bits (definition under Operation); updated together with `product`.

## Operation
- States and transitions:
  - IDLE: to LOADB when `start`=1.
  - LOADB: always to CALC.
  - CALC: runs exactly WIDTH cycles, then to DONE.
  - DONE: to LOADB if `start`=1, else to IDLE.
- On accepting `start` (in IDLE or DONE):
  - Latch `sgn`.
  - Latch |A| into the multiplicand register; in signed mode take the magnitude, else use A as is.
  - Latch sign(A).
- In LOADB:
  - Latch |B| into the multiplier shift register and latch sign(B).
  - Clear the internal accumulator (2*WIDTH bits).
  - Load the counter with WIDTH-1.
- Each CALC cycle:
  - If multiplier LSB = 1, add the multiplicand, shifted left by the iteration index, to the accumulator.
  - Shift the multiplier right by 1 and decrement the counter.
  - Leave CALC when the counter is 0 at the clock edge.
- On the final CALC edge, write `product` with the final accumulator value. In signed mode, negate it (two's complement, 2*WIDTH bits) if sign(A) XOR sign(B).
- Magnitude of the most-negative value is 2^(WIDTH-1), represented as an unsigned WIDTH-bit value; no saturation.
- `ovf`:
  - Unsigned mode: `product`[2W-1:W] != 0.
  - Signed mode: `product`[2W-1:W-1] is not all-0s or all-1s.
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- Arithmetic is exact. Latency is independent of operand values; B=0 still takes WIDTH CALC cycles.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `product`=0, `ovf`=0; internal registers 0.
- `rst` in any state, including mid-CALC, aborts the operation and applies the reset values on that edge. The aborted operation produces no `done`.
- Edge 0: `start`=1 and A sampled.
- Edge 1: B sampled.
- Edges 2 … WIDTH+1: CALC iterations; `product` and `ovf` are written on edge WIDTH+1.
- `done` is high for exactly one cycle, between edges WIDTH+1 and WIDTH+2. For WIDTH=16 this is 18 cycles from start acceptance.
- `product` and `ovf` are valid from the `done` cycle onward. They are held through IDLE, LOADB and CALC of the next operation, until its final CALC edge.
- Back-to-back operation: `start`=1 in the DONE cycle gives a next operation with no idle cycle, for a throughput of one result per WIDTH+2 cycles.
- `busy` and `done` are never high at the same time.

## Test plan
- WIDTH=16, unsigned, A=17 then B=5 → `product`=85, `ovf`=0, `done` pulse exactly 18 cycles after start acceptance, `busy` high for cycles 1–17.
- WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF → `product`=0xFFFE0001, `ovf`=1; also A=0, B=1234 → `product`=0, same latency.
- WIDTH=16, signed:
  - A=-3, B=7 → `product`=0xFFFFFFEB, `ovf`=0.
  - A=-32768, B=-32768 → `product`=0x40000000, `ovf`=1.
  - A=-1, B=-1 → `product`=1, `ovf`=0.
- Handshake:
  - `start` pulsed in mid-CALC is ignored; result and `done` timing are unchanged.
  - `start` asserted in the DONE cycle with a new operand pair is accepted; the second `done` arrives exactly 18 cycles after the first.
- `rst` asserted for 1 cycle at CALC iteration 5 → next cycle `busy`=0, `done`=0, `product`=0, `ovf`=0; no `done` pulse follows; a fresh 17×5 then completes correctly.
- WIDTH=8, signed, A=-128, B=127 → `product`=0xC080 (-16256), `ovf`=1, `done` 10 cycles after start acceptance.
